tpu_result_checker: RTL and testbench
=====================================

# tpu_result_checker

Hardware built-in self-test block for the TPU product buffer. It streams a result matrix P and a golden matrix E out of two BRAM read ports, row by row. Each row is compared lane by lane over the active column count. The block reports pass/fail, a saturating mismatch count and the first failing row and lane. It sits beside `tpu` on the PYNQ-Z2 fabric and is started by the controller after the TPU's `valid_o`, so results are checked on-chip rather than by a bench.

## Interface
- `ADDR_WIDTH`, 12: BRAM address width.
- `LANE_WIDTH`, 16: bits per matrix element (lane).
- `LANES`, 16: lanes per BRAM word; `WORD_WIDTH = LANES*LANE_WIDTH`.
- `RD_LATENCY`, 1: BRAM read latency in cycles, legal range 1..3.
- `CNT_WIDTH`, 16: mismatch counter width.

- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `abort_i` in 1: abandons the current check.
- `m_i` in ADDR_WIDTH: number of rows.
- `n_i` in ADDR_WIDTH: number of active lanes per row.
- `base_addrp_i` in ADDR_WIDTH: base address of the P matrix.
- `base_addre_i` in ADDR_WIDTH: base address of the E matrix.
- `enp_o` out 1: P read enable.
- `addrp_o` out ADDR_WIDTH: P read address.
- `wordp_i` in WORD_WIDTH: P read data.
- `ene_o` out 1: E read enable.
- `addre_o` out ADDR_WIDTH: E read address.
- `worde_i` in WORD_WIDTH: E read data.
- `busy_o` out 1: high from the cycle after start until the done cycle inclusive.
- `done_o` out 1: one-cycle completion pulse.
- `pass_o` out 1: error count is zero; valid when `done_o` is high and held until the next start.
- `err_count_o` out CNT_WIDTH: number of mismatched lanes, saturating.
- `first_err_row_o` out ADDR_WIDTH: row offset of the first mismatch.
- `first_err_lane_o` out $clog2(LANES): lowest mismatching lane in the first failing row.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on `start_i`.
  - ISSUE → DRAIN after row m−1 is issued.
  - DRAIN → DONE when the compare pipeline is empty.
  - DONE → IDLE unconditionally.
- Start handling:
  - On start, latch `m_i`, `base_addrp_i` and `base_addre_i`.
  - Latch n clamped to LANES, so `n_i > LANES` is treated as LANES.
  - Clear the counter and the first-error registers.
  - Inputs sampled at start are never re-sampled during a check.
- ISSUE state:
  - Assert `enp_o` and `ene_o` for exactly one row per cycle.
  - `addrp_o = base_p + r` and `addre_o = base_e + r`, both modulo 2^ADDR_WIDTH, so addresses wrap past all-ones.
- Valid pipeline:
  - A RD_LATENCY-deep shift register carries (valid, row) alongside each read.
  - When an entry emerges, the block compares `wordp_i` and `worde_i` that cycle.
- Compare:
  - Lane j mismatches iff j < n and the two LANE_WIDTH slices differ.
  - Lanes j ≥ n are ignored.
  - The mismatch popcount is added to `err_count_o`, saturating at all-ones.
- First-error capture:
  - On the first row with any mismatch, capture the row and the lowest mismatching lane.
  - These registers are not updated afterwards.
- Boundary cases:
  - `m_i = 0`: no reads are issued; the block goes to DONE with pass=1.
  - n = 0: all lanes are masked and pass=1, but reads are still issued.
- Start while busy: ignored, with no effect on the running check.
- `abort_i`:
  - In ISSUE or DRAIN it forces IDLE on the next edge and flushes the pipeline.
  - No `done_o` is produced and result outputs keep their partial values.
  - `abort_i` together with `start_i` in IDLE: abort wins and no start occurs.
- Reset: every output and register goes to 0 and the FSM to IDLE immediately, including mid-check.

## Timing
- Reset values: all outputs 0, including `pass_o`.
- Reads: start sampled at edge T; row r read is presented in cycle T+1+r.
- Compare: data arrives in cycle T+1+r+RD_LATENCY and is compared that cycle; counters update at the following edge.
- Done and results:
  - `done_o` is high in cycle T+1+m+RD_LATENCY, so latency is m+RD_LATENCY+1 cycles.
  - Final `err_count_o`, `pass_o` and the first-error outputs are stable in that same cycle.
  - For m=0, `done_o` is high in cycle T+1.
- Restart: the earliest restart is the edge after the done cycle.
- Read enables are never asserted outside ISSUE.

## Structure
- `def.v` holds ADDR_WIDTH, LANE_WIDTH, LANES, WORD_WIDTH and the FSM state encodings. These are shared with `tpu`.
- Sub-module `tpu_lane_cmp` is combinational and has these ports:
  - inputs: two words and n;
  - outputs: mismatch mask, popcount and lowest set index.
- The top level holds the FSM, row counter, latency pipeline and result registers.

## Test plan
- Identity check: m=10, n=10, RD_LATENCY=1, P = E = (i+1)(j+1)·2 → done at T+12, pass=1, err_count=0.
- Single fault: as above, but P row 3 lane 7 is corrupted → err_count=1, first_err_row=3, first_err_lane=7, pass=0.
- Masking and clamping:
  - Garbage in lanes ≥ 10 with n=10 → pass=1.
  - n=20 with LANES=16 → all 16 lanes checked.
- Latency and wrap: RD_LATENCY=3, base_p=0xFFE, m=4 → addrp sequence FFE, FFF, 000, 001, with done at T+8.
- Edge cases:
  - m=0 → done at T+1, pass=1, no enables.
  - Start pulsed while busy → ignored.
  - Saturation: CNT_WIDTH=4, 20 mismatches → err_count=15.
- Abort and reset:
  - `abort_i` in cycle T+5 → IDLE next edge, no done pulse, enables drop.
  - `rst_i` mid-DRAIN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/tpu_result_checker_pkg.sv
// Shared definitions for the TPU product-buffer result checker: default
// geometry of the BRAM words and the encoding of the checker FSM states.
package tpu_result_checker_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_LANE_WIDTH = 16;
    localparam int DEF_LANES      = 16;
    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tpu_result_checker_lane_cmp.sv
// Lane-wise comparator for one row: compares two BRAM words lane by lane
// over the first n lanes and reports the mismatch mask, how many lanes
// mismatched and the lowest mismatching lane index.
module tpu_lane_cmp #(
    parameter int LANES      = 16,
    parameter int LANE_WIDTH = 16
) (
    input  logic [LANES*LANE_WIDTH-1:0] word_a,
    input  logic [LANES*LANE_WIDTH-1:0] word_b,
    input  logic [$clog2(LANES):0]      n,
    output logic [LANES-1:0]            mismatch,
    output logic [$clog2(LANES):0]      popcnt,
    output logic [$clog2(LANES)-1:0]    low_idx
);

    localparam int LIDX_W = $clog2(LANES);
    localparam int N_W    = LIDX_W + 1;

    // Mask compare by active lane count, then count and locate mismatches.
    always_comb begin
        // NOTE: every output is given a default before any conditional update, so no path leaves one unassigned and no latch is inferred.
        mismatch = '0;
        popcnt   = '0;
        low_idx  = '0;
        for (int j = 0; j < LANES; j++) begin
            mismatch[j] = (N_W'(j) < n) &&
                          (word_a[j*LANE_WIDTH +: LANE_WIDTH] != word_b[j*LANE_WIDTH +: LANE_WIDTH]);
        end
        for (int j = 0; j < LANES; j++) begin
            popcnt = popcnt + N_W'(mismatch[j]);
        end
        // Scan downwards so the last hit written is the lowest lane.
        for (int j = LANES - 1; j >= 0; j--) begin
            if (mismatch[j]) begin
                low_idx = LIDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tpu_result_checker.sv
// On-chip result checker for the TPU product buffer. Streams the result
// matrix P and golden matrix E row by row out of two BRAM read ports,
// compares them lane by lane and reports pass/fail, a saturating mismatch
// count and the location of the first mismatch.
module tpu_result_checker
    import tpu_result_checker_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LANE_WIDTH = DEF_LANE_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [ADDR_WIDTH-1:0]         m_i,
    input  logic [ADDR_WIDTH-1:0]         n_i,
    input  logic [ADDR_WIDTH-1:0]         base_addrp_i,
    input  logic [ADDR_WIDTH-1:0]         base_addre_i,
    output logic                          enp_o,
    output logic [ADDR_WIDTH-1:0]         addrp_o,
    input  logic [LANES*LANE_WIDTH-1:0]   wordp_i,
    output logic                          ene_o,
    output logic [ADDR_WIDTH-1:0]         addre_o,
    input  logic [LANES*LANE_WIDTH-1:0]   worde_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic [CNT_WIDTH-1:0]          err_count_o,
    output logic [ADDR_WIDTH-1:0]         first_err_row_o,
    output logic [$clog2(LANES)-1:0]      first_err_lane_o
);

    localparam int LIDX_W = $clog2(LANES);
    localparam int N_W    = LIDX_W + 1;
    localparam int SUM_W  = ((CNT_WIDTH > N_W) ? CNT_WIDTH : N_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});
    // Every pipeline stage except the one currently being compared.
    localparam logic [RD_LATENCY-1:0] EARLY_MASK = {RD_LATENCY{1'b1}} >> 1;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   m_q;
    logic [N_W-1:0]          n_q;
    logic [ADDR_WIDTH-1:0]   row_q;
    logic [RD_LATENCY-1:0]   vld_q;
    logic [ADDR_WIDTH-1:0]   row_pipe_q [RD_LATENCY];
    logic                    first_seen_q;

    logic                    start_go;
    logic                    abort_go;
    logic                    cmp_valid;
    logic [ADDR_WIDTH-1:0]   cmp_row;
    logic                    drain_empty;
    logic [N_W-1:0]          n_clamped;
    logic [LANES-1:0]        mismatch;
    logic [N_W-1:0]          popcnt;
    logic [LIDX_W-1:0]       low_idx;
    logic [SUM_W-1:0]        err_sum;
    logic [CNT_WIDTH-1:0]    err_next;

    // Abort outranks start in IDLE; abort only acts while a check is running.
    assign start_go    = (state_q == ST_IDLE) && start_i && !abort_i;
    assign abort_go    = abort_i && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    assign n_clamped   = (n_i > ADDR_WIDTH'(LANES)) ? N_W'(LANES) : N_W'(n_i);
    assign cmp_valid   = vld_q[RD_LATENCY-1];
    assign cmp_row     = row_pipe_q[RD_LATENCY-1];
    assign drain_empty = ~|(vld_q & EARLY_MASK);

    tpu_lane_cmp #(
        .LANES      (LANES),
        .LANE_WIDTH (LANE_WIDTH)
    ) u_lane_cmp (
        .word_a   (wordp_i),
        .word_b   (worde_i),
        .n        (n_q),
        .mismatch (mismatch),
        .popcnt   (popcnt),
        .low_idx  (low_idx)
    );

    // Saturating accumulation of this cycle's mismatch count.
    always_comb begin
        err_sum  = SUM_W'(err_count_o) + SUM_W'(popcnt);
        err_next = err_count_o;
        if (cmp_valid) begin
            err_next = (err_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];
        end
    end

    // Control FSM: sequences reads, drives the read ports and completion flags.
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            row_q   <= '0;
            enp_o   <= 1'b0;
            ene_o   <= 1'b0;
            addrp_o <= '0;
            addre_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            pass_o  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        m_q     <= m_i;
                        n_q     <= n_clamped;
                        row_q   <= '0;
                        addrp_o <= base_addrp_i;
                        addre_o <= base_addre_i;
                        busy_o  <= 1'b1;
                        pass_o  <= 1'b0;
                        if (m_i == '0) begin
                            state_q <= ST_DONE;
                            done_o  <= 1'b1;
                            pass_o  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            enp_o   <= 1'b1;
                            ene_o   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort_go) begin
                        state_q <= ST_IDLE;
                        enp_o   <= 1'b0;
                        ene_o   <= 1'b0;
                        busy_o  <= 1'b0;
                    end else if (row_q == m_q - ADDR_WIDTH'(1)) begin
                        state_q <= ST_DRAIN;
                        enp_o   <= 1'b0;
                        ene_o   <= 1'b0;
                    end else begin
                        row_q   <= row_q + ADDR_WIDTH'(1);
                        addrp_o <= addrp_o + ADDR_WIDTH'(1);
                        addre_o <= addre_o + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (abort_go) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (drain_empty) begin
                        state_q <= ST_DONE;
                        done_o  <= 1'b1;
                        pass_o  <= (err_next == '0);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read-latency pipeline: carries (valid, row) alongside each BRAM read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            // NOTE: the row tags are reset as well, so the whole block comes up in a known all-zero state.
            for (int k = 0; k < RD_LATENCY; k++) begin
                row_pipe_q[k] <= '0;
            end
        end else if (abort_go) begin
            vld_q <= '0;
        end else begin
            vld_q[0]      <= enp_o;
            row_pipe_q[0] <= row_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_q[k]      <= vld_q[k-1];
                row_pipe_q[k] <= row_pipe_q[k-1];
            end
        end
    end

    // Result registers: error count and first-failure location.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_count_o      <= '0;
            first_err_row_o  <= '0;
            first_err_lane_o <= '0;
            first_seen_q     <= 1'b0;
        end else if (start_go) begin
            err_count_o      <= '0;
            first_err_row_o  <= '0;
            first_err_lane_o <= '0;
            first_seen_q     <= 1'b0;
        end else if (cmp_valid && !abort_go) begin
            err_count_o <= err_next;
            if (!first_seen_q && (|mismatch)) begin
                first_seen_q     <= 1'b1;
                first_err_row_o  <= cmp_row;
                first_err_lane_o <= low_idx;
            end
        end
    end

endmodule

// File: tb/tb_tpu_result_checker.sv
// Directed bench for tpu_result_checker. Instance A uses the default
// parameters (RD_LATENCY=1); instance B uses RD_LATENCY=3 and CNT_WIDTH=4.
module tb_tpu_result_checker;
    import tpu_result_checker_pkg::*;

    localparam int AW = 12;
    localparam int LW = 16;
    localparam int LN = 16;
    localparam int WW = LN * LW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_a, start_b, abort_i;
    logic [AW-1:0] m_i, n_i, bp_i, be_i;

    logic          enp_a, ene_a, busy_a, done_a, pass_a;
    logic [AW-1:0] addrp_a, addre_a, frow_a;
    logic [15:0]   err_a;
    logic [3:0]    flane_a;
    logic [WW-1:0] wordp_a, worde_a;

    logic          enp_b, ene_b, busy_b, done_b, pass_b;
    logic [AW-1:0] addrp_b, addre_b, frow_b;
    logic [3:0]    err_b;
    logic [3:0]    flane_b;
    logic [WW-1:0] wordp_b, worde_b;
    logic [WW-1:0] p_b1, p_b2, p_b3, e_b1, e_b2, e_b3;

    tpu_result_checker dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_i),
        .m_i(m_i), .n_i(n_i), .base_addrp_i(bp_i), .base_addre_i(be_i),
        .enp_o(enp_a), .addrp_o(addrp_a), .wordp_i(wordp_a),
        .ene_o(ene_a), .addre_o(addre_a), .worde_i(worde_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
        .first_err_row_o(frow_a), .first_err_lane_o(flane_a)
    );

    tpu_result_checker #(.RD_LATENCY(3), .CNT_WIDTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_i),
        .m_i(m_i), .n_i(n_i), .base_addrp_i(bp_i), .base_addre_i(be_i),
        .enp_o(enp_b), .addrp_o(addrp_b), .wordp_i(wordp_b),
        .ene_o(ene_b), .addre_o(addre_b), .worde_i(worde_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
        .first_err_row_o(frow_b), .first_err_lane_o(flane_b)
    );

    // BRAM models: latency 1 for A, latency 3 for B.
    logic [WW-1:0] mem_p [4096];
    logic [WW-1:0] mem_e [4096];

    always @(posedge clk) begin
        if (enp_a) wordp_a <= mem_p[addrp_a];
        if (ene_a) worde_a <= mem_e[addre_a];
        if (enp_b) p_b1 <= mem_p[addrp_b];
        if (ene_b) e_b1 <= mem_e[addre_b];
        p_b2 <= p_b1;
        p_b3 <= p_b2;
        e_b2 <= e_b1;
        e_b3 <= e_b2;
    end
    assign wordp_b = p_b3;
    assign worde_b = e_b3;

    // Selected-instance view used by the generic run task.
    logic          sel_b;
    logic          en_s, ene_s, busy_s, done_s, pass_s;
    logic [AW-1:0] addrp_s, addre_s, frow_s;
    logic [15:0]   err_s;
    logic [3:0]    flane_s;
    assign en_s    = sel_b ? enp_b   : enp_a;
    assign ene_s   = sel_b ? ene_b   : ene_a;
    assign busy_s  = sel_b ? busy_b  : busy_a;
    assign done_s  = sel_b ? done_b  : done_a;
    assign pass_s  = sel_b ? pass_b  : pass_a;
    assign addrp_s = sel_b ? addrp_b : addrp_a;
    assign addre_s = sel_b ? addre_b : addre_a;
    assign frow_s  = sel_b ? frow_b  : frow_a;
    assign err_s   = sel_b ? {12'h000, err_b} : err_a;
    assign flane_s = sel_b ? flane_b : flane_a;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] addr_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] elem(input int i, input int j);
        return 16'((i + 1) * (j + 1) * 2);
    endfunction

    task automatic fill(input int bp, input int be, input int rows);
        for (int i = 0; i < rows; i++) begin
            for (int j = 0; j < LN; j++) begin
                mem_p[(bp + i) % 4096][j*LW +: LW] = elem(i, j);
                mem_e[(be + i) % 4096][j*LW +: LW] = elem(i, j);
            end
        end
    endtask

    task automatic corrupt(input int bp, input int row, input logic [15:0] mask);
        if (row >= 0) begin
            for (int j = 0; j < LN; j++) begin
                if (mask[j]) begin
                    mem_p[(bp + row) % 4096][j*LW +: LW] = mem_p[(bp + row) % 4096][j*LW +: LW] ^ 16'h5A5A;
                end
            end
        end
    endtask

    // Start one check; optionally re-pulse start with new inputs at cycle 'poke'.
    task automatic run(input bit use_b, input int m, input int n, input int bp, input int be,
                       input int poke, output int lat, output int reads, output int bad,
                       output logic busy1);
        sel_b = use_b;
        m_i   = AW'(m);
        n_i   = AW'(n);
        bp_i  = AW'(bp);
        be_i  = AW'(be);
        addr_log.delete();
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 0; reads = 0; bad = 0;
        busy1 = busy_s;
        for (int c = 1; c <= 300; c++) begin
            if (poke != 0 && c == poke) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
                m_i = AW'(2); n_i = '0; bp_i = AW'('h123); be_i = AW'('h321);
            end else if (poke != 0 && c == poke + 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (ene_s !== en_s) bad++;
            if (en_s) begin
                if (addrp_s !== AW'(bp + reads)) bad++;
                if (addre_s !== AW'(be + reads)) bad++;
                addr_log.push_back(addrp_s);
                reads++;
            end
            if (done_s) begin
                lat = c;
                break;
            end
            step();
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          m, n, bp, be;
        int          r1;
        logic [15:0] k1;
        int          r2;
        logic [15:0] k2;
        int          lat;
        logic        pass;
        int          err, row, lane;
    } vec_t;

    function automatic vec_t mkv(input string name, input int m, input int n, input int bp,
                                 input int be, input int r1, input logic [15:0] k1, input int r2,
                                 input logic [15:0] k2, input int lat, input logic pass,
                                 input int err, input int row, input int lane);
        vec_t v;
        v.name = name; v.m = m; v.n = n; v.bp = bp; v.be = be;
        v.r1 = r1; v.k1 = k1; v.r2 = r2; v.k2 = k2;
        v.lat = lat; v.pass = pass; v.err = err; v.row = row; v.lane = lane;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t vecs[10];
    vec_t v;
    int lat, reads, bad, cnt;
    logic busy1;
    logic [AW-1:0] wrap_exp [4];

    initial begin
        rst = 1'b1; start_a = 0; start_b = 0; abort_i = 0; sel_b = 0;
        m_i = '0; n_i = '0; bp_i = '0; be_i = '0;
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;

        //          name      m   n   bp     be     r1  k1       r2  k2       lat pass err row lane
        vecs[0] = mkv("ident", 10, 10, 'h000, 'h200, -1, 16'h0000, -1, 16'h0000, 12, 1'b1, 0, 0, 0);
        vecs[1] = mkv("single",10, 10, 'h010, 'h210,  3, 16'h0080, -1, 16'h0000, 12, 1'b0, 1, 3, 7);
        vecs[2] = mkv("masked",10, 10, 'h020, 'h220,  2, 16'hFC00,  7, 16'h8400, 12, 1'b1, 0, 0, 0);
        vecs[3] = mkv("clamp20",6, 20, 'h030, 'h230,  5, 16'h9000, -1, 16'h0000,  8, 1'b0, 2, 5, 12);
        vecs[4] = mkv("multi",  6, 16, 'h040, 'h240,  1, 16'h0001,  4, 16'h00F0,  8, 1'b0, 5, 1, 0);
        vecs[5] = mkv("n0",     3,  0, 'h050, 'h250,  0, 16'hFFFF, -1, 16'h0000,  5, 1'b1, 0, 0, 0);
        vecs[6] = mkv("m1n1",   1,  1, 'h060, 'h260,  0, 16'h0003, -1, 16'h0000,  3, 1'b0, 1, 0, 0);
        vecs[7] = mkv("m0",     0,  5, 'h070, 'h270, -1, 16'h0000, -1, 16'h0000,  1, 1'b1, 0, 0, 0);
        vecs[8] = mkv("lowidx", 4, 16, 'h080, 'h280,  2, 16'h0A00,  3, 16'h0002,  6, 1'b0, 3, 2, 9);
        vecs[9] = mkv("clamp33",3, 33, 'h090, 'h290,  1, 16'h8000, -1, 16'h0000,  5, 1'b0, 1, 1, 15);

        // Reset state of both instances.
        step();
        step();
        check("reset.a", 64'({enp_a, addrp_a, ene_a, addre_a, busy_a, done_a, pass_a, err_a, frow_a, flane_a}), 64'd0);
        check("reset.b", 64'({enp_b, addrp_b, ene_b, addre_b, busy_b, done_b, pass_b, err_b, frow_b, flane_b}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table-driven checks on instance A.
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            fill(v.bp, v.be, v.m);
            corrupt(v.bp, v.r1, v.k1);
            corrupt(v.bp, v.r2, v.k2);
            run(1'b0, v.m, v.n, v.bp, v.be, 0, lat, reads, bad, busy1);
            check({v.name, ".latency"}, 64'(lat), 64'(v.lat));
            check({v.name, ".busy1"}, 64'(busy1), 64'd1);
            check({v.name, ".pass"}, 64'(pass_s), 64'(v.pass));
            check({v.name, ".err"}, 64'(err_s), 64'(v.err));
            check({v.name, ".row"}, 64'(frow_s), 64'(v.row));
            check({v.name, ".lane"}, 64'(flane_s), 64'(v.lane));
            check({v.name, ".reads"}, 64'(reads), 64'(v.m));
            check({v.name, ".addr"}, 64'(bad), 64'd0);
            step();
            check({v.name, ".after"}, 64'({done_s, busy_s, en_s}), 64'd0);
            check({v.name, ".pass_hold"}, 64'(pass_s), 64'(v.pass));
        end

        // Latency 3 with address wrap on instance B.
        fill('hFFE, 'h7F0, 4);
        run(1'b1, 4, 16, 'hFFE, 'h7F0, 0, lat, reads, bad, busy1);
        check("wrap.latency", 64'(lat), 64'd8);
        check("wrap.pass", 64'(pass_s), 64'd1);
        check("wrap.err", 64'(err_s), 64'd0);
        check("wrap.addr", 64'(bad), 64'd0);
        check("wrap.nlog", 64'(addr_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
            check($sformatf("wrap.addrp%0d", k), 64'(addr_log[k]), 64'(wrap_exp[k]));
        end
        step();
        check("wrap.after", 64'({done_s, busy_s}), 64'd0);

        // Saturating counter on instance B (20 mismatches, 4-bit count).
        fill('h100, 'h300, 2);
        corrupt('h100, 0, 16'hFFFF);
        corrupt('h100, 1, 16'h000F);
        run(1'b1, 2, 16, 'h100, 'h300, 0, lat, reads, bad, busy1);
        check("sat.latency", 64'(lat), 64'd6);
        check("sat.err", 64'(err_s), 64'd15);
        check("sat.pass", 64'(pass_s), 64'd0);
        check("sat.rowlane", 64'({frow_s, flane_s}), 64'd0);
        step();

        // Start pulsed while busy, with changed inputs, is ignored.
        fill('h400, 'h500, 10);
        corrupt('h400, 6, 16'h0001);
        run(1'b0, 10, 10, 'h400, 'h500, 3, lat, reads, bad, busy1);
        check("busystart.latency", 64'(lat), 64'd12);
        check("busystart.err", 64'(err_s), 64'd1);
        check("busystart.row", 64'(frow_s), 64'd6);
        check("busystart.reads", 64'(reads), 64'd10);
        check("busystart.addr", 64'(bad), 64'd0);
        step();
        check("busystart.after", 64'({done_s, busy_s}), 64'd0);

        // Abort in cycle T+5 on instance A.
        fill('h600, 'h700, 10);
        sel_b = 1'b0;
        m_i = AW'(10); n_i = AW'(10); bp_i = AW'('h600); be_i = AW'('h700);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c < 5; c++) step();
        check("abort.pre", 64'({busy_a, enp_a}), 64'b11);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort.idle", 64'({busy_a, enp_a, ene_a, done_a}), 64'd0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_a || busy_a) cnt++;
            step();
        end
        check("abort.no_done", 64'(cnt), 64'd0);

        // Abort together with start in IDLE: no start.
        start_a = 1'b1;
        abort_i = 1'b1;
        step();
        start_a = 1'b0;
        abort_i = 1'b0;
        check("abortstart.idle", 64'({busy_a, enp_a}), 64'd0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_a) cnt++;
            step();
        end
        check("abortstart.no_done", 64'(cnt), 64'd0);

        // Clean restart after abort.
        run(1'b0, 3, 16, 'h600, 'h700, 0, lat, reads, bad, busy1);
        check("restart.latency", 64'(lat), 64'd5);
        check("restart.pass", 64'(pass_s), 64'd1);
        check("restart.err", 64'(err_s), 64'd0);
        step();

        // Asynchronous reset mid-DRAIN on instance B.
        fill('h800, 'h900, 2);
        corrupt('h800, 0, 16'h0003);
        sel_b = 1'b1;
        m_i = AW'(2); n_i = AW'(16); bp_i = AW'('h800); be_i = AW'('h900);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 1; c < 5; c++) step();
        check("rst.pre_err", 64'(err_b), 64'd2);
        check("rst.pre_busy", 64'({busy_b, enp_b}), 64'b10);
        #2;
        rst = 1'b1;
        #1;
        check("rst.async", 64'({enp_b, addrp_b, ene_b, addre_b, busy_b, done_b, pass_b, err_b, frow_b, flane_b}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst.after", 64'({busy_b, done_b}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
